// File: rtl/oflow_history_line_fetcher.sv
// rtl/oflow_history_line_fetcher.sv - read-side line sequencer for the history-frame buffer wrapper
// Issues start_read/read_new_line, waits the wrapper latency and presents each line over valid/ready.
module oflow_history_line_fetcher #(
  parameter int DATA_WIDTH                  = 64,
  parameter int NUM_OF_HISTORY_FRAMES_WIDTH = 3,
  parameter int NUM_OF_BBOX_IN_FRAME_WIDTH  = 6,
  parameter int START_LAT                   = 1,
  parameter int LINE_LAT                    = 2
) (
  input  logic                                   clk,
  input  logic                                   reset_N,
  input  logic                                   start_fetch,
  input  logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] num_of_history_frames,
  input  logic [NUM_OF_BBOX_IN_FRAME_WIDTH-1:0]  num_of_bbox_in_frame,
  output logic                                   rnw_st,
  output logic                                   start_read,
  output logic                                   read_new_line,
  input  logic                                   done_read,
  input  logic [DATA_WIDTH-1:0]                  mem_data_0,
  input  logic [DATA_WIDTH-1:0]                  mem_data_1,
  output logic                                   line_valid,
  input  logic                                   line_ready,
  output logic [DATA_WIDTH-1:0]                  line_data_0,
  output logic [DATA_WIDTH-1:0]                  line_data_1,
  output logic                                   line_pair_valid,
  output logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] line_frame_idx,
  output logic [NUM_OF_BBOX_IN_FRAME_WIDTH-1:0]  line_idx,
  output logic                                   fetch_busy,
  output logic                                   fetch_done
);

  localparam int HW = NUM_OF_HISTORY_FRAMES_WIDTH;
  localparam int BW = NUM_OF_BBOX_IN_FRAME_WIDTH;
  localparam int CW = HW + BW;
  localparam int WW = 8;

  localparam logic [WW-1:0] START_CNT = WW'(START_LAT);
  localparam logic [WW-1:0] LINE_CNT  = WW'(LINE_LAT);
  localparam logic [WW-1:0] W_ONE     = WW'(1);
  localparam logic [BW-1:0] B_ONE     = BW'(1);
  localparam logic [HW-1:0] H_ONE     = HW'(1);
  localparam logic [CW-1:0] C_ONE     = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_DONE} state_t;

  state_t        state, next_state;
  logic [HW-1:0] h_q;
  logic [BW-1:0] b_q;
  logic [BW-1:0] lines_per_frame;
  logic [CW-1:0] total_lines;
  logic [CW-1:0] line_cnt;
  logic [CW-1:0] line_cnt_nxt;
  logic [WW-1:0] wait_cnt;
  logic          done_lat;
  logic          accept;
  logic          empty_cfg;
  logic          capture;
  logic          handshake;
  logic          lines_remain;
  logic          last_in_frame;

  // ceil(B/2) without needing an extra bit, and T at full width so it never truncates
  assign lines_per_frame = (b_q >> 1) + {{(BW-1){1'b0}}, b_q[0]};
  assign total_lines     = {{BW{1'b0}}, h_q} * {{HW{1'b0}}, lines_per_frame};
  assign line_cnt_nxt    = line_cnt + C_ONE;
  assign lines_remain    = line_cnt_nxt < total_lines;
  assign last_in_frame   = line_idx == (lines_per_frame - B_ONE);

  assign accept    = (state == S_IDLE) && start_fetch;
  assign empty_cfg = (num_of_history_frames == '0) || (num_of_bbox_in_frame == '0);
  assign capture   = (state == S_WAIT) && (wait_cnt == W_ONE);
  assign handshake = (state == S_HOLD) && line_ready;

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (start_fetch) next_state = empty_cfg ? S_DONE : S_WAIT;
      S_WAIT: if (capture) next_state = S_HOLD;
      S_HOLD: if (line_ready) next_state = (lines_remain && !done_lat) ? S_WAIT : S_DONE;
      S_DONE: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    start_read    = 1'b0;
    read_new_line = 1'b0;
    fetch_busy    = 1'b0;
    rnw_st        = 1'b0;
    fetch_done    = 1'b0;
    case (state)
      S_IDLE: start_read = start_fetch && !empty_cfg;
      S_WAIT: begin
        fetch_busy = 1'b1;
        rnw_st     = 1'b1;
      end
      S_HOLD: begin
        fetch_busy    = 1'b1;
        rnw_st        = 1'b1;
        read_new_line = line_ready && lines_remain && !done_lat;
      end
      S_DONE: begin
        fetch_busy = 1'b1;
        rnw_st     = 1'b1;
        fetch_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      h_q            <= '0;
      b_q            <= '0;
      line_cnt       <= '0;
      wait_cnt       <= '0;
      done_lat       <= 1'b0;
      line_valid     <= 1'b0;
      line_data_0    <= '0;
      line_data_1    <= '0;
      line_frame_idx <= '0;
      line_idx       <= '0;
    end else begin
      if (state == S_IDLE) begin
        done_lat <= 1'b0;
      end else if (done_read) begin
        done_lat <= 1'b1;
      end
      if (accept) begin
        h_q            <= num_of_history_frames;
        b_q            <= num_of_bbox_in_frame;
        line_cnt       <= '0;
        line_frame_idx <= '0;
        line_idx       <= '0;
        wait_cnt       <= START_CNT;
      end
      if (state == S_WAIT) begin
        wait_cnt <= wait_cnt - W_ONE;
        if (capture) begin
          line_data_0 <= mem_data_0;
          line_data_1 <= mem_data_1;
          line_valid  <= 1'b1;
        end
      end
      if (handshake) begin
        line_valid <= 1'b0;
        line_cnt   <= line_cnt_nxt;
        if (last_in_frame) begin
          line_idx       <= '0;
          line_frame_idx <= line_frame_idx + H_ONE;
        end else begin
          line_idx <= line_idx + B_ONE;
        end
        if (read_new_line) wait_cnt <= LINE_CNT;
      end
    end
  end

  // the padding flag only has meaning while a line is presented
  assign line_pair_valid = line_valid && !(b_q[0] && last_in_frame);

endmodule

// File: tb/tb_oflow_history_line_fetcher.sv
// tb/tb_oflow_history_line_fetcher.sv - randomized self-checking bench for oflow_history_line_fetcher
module tb_oflow_history_line_fetcher;

  localparam int DW = 64;
  localparam int HW = 3;
  localparam int BW = 6;
  localparam int START_LAT = 1;
  localparam int LINE_LAT = 2;

  logic          clk = 1'b0;
  logic          reset_N = 1'b0;
  logic          start_fetch = 1'b0;
  logic [HW-1:0] num_of_history_frames = '0;
  logic [BW-1:0] num_of_bbox_in_frame = '0;
  logic          done_read = 1'b0;
  logic          line_ready = 1'b0;
  logic [DW-1:0] mem_data_0, mem_data_1;
  logic          rnw_st, start_read, read_new_line, line_valid, line_pair_valid;
  logic          fetch_busy, fetch_done;
  logic [DW-1:0] line_data_0, line_data_1;
  logic [HW-1:0] line_frame_idx;
  logic [BW-1:0] line_idx;

  oflow_history_line_fetcher #(
    .DATA_WIDTH(DW), .NUM_OF_HISTORY_FRAMES_WIDTH(HW), .NUM_OF_BBOX_IN_FRAME_WIDTH(BW),
    .START_LAT(START_LAT), .LINE_LAT(LINE_LAT)
  ) dut (
    .clk(clk), .reset_N(reset_N), .start_fetch(start_fetch),
    .num_of_history_frames(num_of_history_frames), .num_of_bbox_in_frame(num_of_bbox_in_frame),
    .rnw_st(rnw_st), .start_read(start_read), .read_new_line(read_new_line), .done_read(done_read),
    .mem_data_0(mem_data_0), .mem_data_1(mem_data_1), .line_valid(line_valid), .line_ready(line_ready),
    .line_data_0(line_data_0), .line_data_1(line_data_1), .line_pair_valid(line_pair_valid),
    .line_frame_idx(line_frame_idx), .line_idx(line_idx), .fetch_busy(fetch_busy), .fetch_done(fetch_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic          pv;
    logic [HW-1:0] f;
    logic [BW-1:0] i;
  } line_t;

  line_t got_q[$];
  line_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // wrapper model: line k is words 2k/2k+1, valid START_LAT after start_read, LINE_LAT after read_new_line
  logic [DW-1:0] words [0:511];
  logic [7:0]    ptr = '0;
  logic          mvalid = 1'b0;
  logic          rnl_q = 1'b0;

  always @(posedge clk) begin
    rnl_q <= read_new_line;
    if (start_read) begin
      ptr <= '0;
      mvalid <= 1'b1;
    end else if (read_new_line) begin
      mvalid <= 1'b0;
    end else if (rnl_q) begin
      ptr <= ptr + 8'd1;
      mvalid <= 1'b1;
    end
  end
  assign mem_data_0 = mvalid ? words[{ptr, 1'b0}] : {2{32'hDEADBEEF}};
  assign mem_data_1 = mvalid ? words[{ptr, 1'b1}] : {2{32'hBADC0FFE}};

  int n_sr = 0, n_rnl = 0, n_done = 0, n_lat = 0, n_stab = 0, n_proto = 0;
  int cyc = 0, last_issue = 0, issue_lat = 0, sf_cyc = 0, done_cyc = 0;
  logic  prev_valid = 1'b0;
  logic  prev_hs = 1'b0;
  line_t prev_line = '0;
  line_t cur_line;
  assign cur_line = '{d0: line_data_0, d1: line_data_1, pv: line_pair_valid, f: line_frame_idx, i: line_idx};

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (reset_N) begin
      if (start_read) begin n_sr <= n_sr + 1; last_issue <= cyc; issue_lat <= START_LAT + 1; end
      if (read_new_line) begin n_rnl <= n_rnl + 1; last_issue <= cyc; issue_lat <= LINE_LAT + 1; end
      if ((start_read && read_new_line) || (read_new_line && !(line_valid && line_ready)))
        n_proto <= n_proto + 1;
      if (line_valid && !prev_valid && (cyc - last_issue) != issue_lat) n_lat <= n_lat + 1;
      if (line_valid && prev_valid && !prev_hs && cur_line != prev_line) n_stab <= n_stab + 1;
      if (line_valid && line_ready) got_q.push_back(cur_line);
      if (fetch_done) begin n_done <= n_done + 1; done_cyc <= cyc; end
      if (start_fetch && !fetch_busy) sf_cyc <= cyc;
      prev_valid <= line_valid;
      prev_hs <= line_valid && line_ready;
      prev_line <= cur_line;
    end else begin
      prev_valid <= 1'b0;
      prev_hs <= 1'b0;
    end
  end

  int b_sr, b_rnl, b_done, b_lat, b_stab, b_proto;
  int guard;

  function automatic void build_exp(input int h, input int b, input int nmax);
    int l, t;
    line_t e;
    exp_q.delete();
    l = (b + 1) / 2;
    t = h * l;
    if (nmax >= 0 && t > nmax) t = nmax;
    for (int k = 0; k < t; k++) begin
      e.d0 = words[2*k];
      e.d1 = words[2*k+1];
      e.pv = !((b % 2 == 1) && (k % l == l - 1));
      e.f  = HW'(k / l);
      e.i  = BW'(k % l);
      exp_q.push_back(e);
    end
  endfunction

  task automatic fill_words;
    for (int i = 0; i < 512; i++) words[i] = {$urandom, $urandom};
  endtask

  task automatic snapshot;
    got_q.delete();
    b_sr = n_sr; b_rnl = n_rnl; b_done = n_done; b_lat = n_lat; b_stab = n_stab; b_proto = n_proto;
  endtask

  // mode 0: ready held high, 1: random ready, 2: stall `stall` cycles per line
  task automatic run_fetch(input int h, input int b, input int mode, input int stall,
                           input bit inj_done, input bit inj_sf);
    int hold;
    bit dpulsed;
    fill_words();
    snapshot();
    @(posedge clk); #1;
    num_of_history_frames = HW'(h);
    num_of_bbox_in_frame = BW'(b);
    start_fetch = 1'b1;
    line_ready = (mode == 0);
    @(posedge clk); #1;
    start_fetch = 1'b0;
    num_of_history_frames = HW'($urandom);
    num_of_bbox_in_frame = BW'($urandom);
    guard = 0; hold = 0; dpulsed = 0;
    while (n_done == b_done && guard < 3000) begin
      hold = line_valid ? hold + 1 : 0;
      case (mode)
        0: line_ready = 1'b1;
        1: line_ready = 1'($urandom_range(0, 1));
        default: line_ready = line_valid && (hold > stall);
      endcase
      done_read = 1'b0;
      if (inj_done && !dpulsed && got_q.size() == 1 && !line_valid && fetch_busy) begin
        done_read = 1'b1;
        dpulsed = 1;
      end
      start_fetch = inj_sf && (guard == 8);
      if (start_fetch) begin
        num_of_history_frames = 3'd7;
        num_of_bbox_in_frame = 6'd9;
      end
      @(posedge clk); #1;
      guard++;
    end
    start_fetch = 1'b0;
    done_read = 1'b0;
    line_ready = 1'b0;
    vectors++;
    if (guard >= 3000) begin
      miscompares++;
      $display("FAIL fetch_timeout: h=%0d b=%0d no fetch_done after %0d cycles", h, b, guard);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_N = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({line_valid, start_read, read_new_line, rnw_st, fetch_busy, fetch_done, line_pair_valid,
         line_frame_idx, line_idx, line_data_0, line_data_1} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got valid=%b sr=%b rnl=%b rnw=%b busy=%b done=%b d0=%h required all 0",
               line_valid, start_read, read_new_line, rnw_st, fetch_busy, fetch_done, line_data_0);
    end
    reset_N = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({line_valid, rnw_st, fetch_busy, fetch_done} !== 4'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got valid=%b rnw=%b busy=%b done=%b required 0",
               line_valid, rnw_st, fetch_busy, fetch_done);
    end
  endtask

  task automatic test_basic;
    run_fetch(2, 4, 0, 0, 0, 0);
    build_exp(2, 4, -1);
    vectors++;
    if (n_sr - b_sr != 1) begin miscompares++; $display("FAIL basic_start_read: got %0d required 1", n_sr - b_sr); end
    vectors++;
    if (n_rnl - b_rnl != 3) begin miscompares++; $display("FAIL basic_read_new_line: got %0d required 3", n_rnl - b_rnl); end
    vectors++;
    if (n_done - b_done != 1) begin miscompares++; $display("FAIL basic_fetch_done: got %0d required 1", n_done - b_done); end
    vectors++;
    if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL basic_lines: got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      vectors++;
      if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin
        miscompares++;
        $display("FAIL basic_line%0d: got %h required %h", k, (k < got_q.size()) ? got_q[k] : '0, exp_q[k]);
      end
    end
    vectors++;
    if (n_lat - b_lat != 0 || n_proto - b_proto != 0) begin
      miscompares++;
      $display("FAIL basic_timing: got latency_errs=%0d proto_errs=%0d required 0", n_lat - b_lat, n_proto - b_proto);
    end
  endtask

  task automatic test_odd;
    run_fetch(1, 3, 0, 0, 0, 0);
    build_exp(1, 3, -1);
    vectors++;
    if (got_q.size() != 2) begin miscompares++; $display("FAIL odd_lines: got %0d required 2", got_q.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      vectors++;
      if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin
        miscompares++;
        $display("FAIL odd_line%0d: got %h required %h", k, (k < got_q.size()) ? got_q[k] : '0, exp_q[k]);
      end
    end
    vectors++;
    if (n_lat - b_lat != 0) begin miscompares++; $display("FAIL odd_latency: got %0d errors required 0", n_lat - b_lat); end
  endtask

  task automatic test_stall;
    run_fetch(3, 2, 2, 5, 0, 1);
    build_exp(3, 2, -1);
    vectors++;
    if (got_q.size() != 3) begin miscompares++; $display("FAIL stall_lines: got %0d required 3", got_q.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      vectors++;
      if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin
        miscompares++;
        $display("FAIL stall_line%0d: got %h required %h", k, (k < got_q.size()) ? got_q[k] : '0, exp_q[k]);
      end
    end
    vectors++;
    if (n_stab - b_stab != 0) begin miscompares++; $display("FAIL stall_stability: got %0d changes required 0", n_stab - b_stab); end
    vectors++;
    if (n_rnl - b_rnl != 2 || n_proto - b_proto != 0) begin
      miscompares++;
      $display("FAIL stall_read_new_line: got %0d pulses, %0d outside handshake required 2 and 0", n_rnl - b_rnl, n_proto - b_proto);
    end
    vectors++;
    if (n_sr - b_sr != 1) begin miscompares++; $display("FAIL stall_busy_start_ignored: got %0d start_read required 1", n_sr - b_sr); end
  endtask

  task automatic test_zero;
    int hs[2] = '{0, 3};
    int bs[2] = '{4, 0};
    for (int z = 0; z < 2; z++) begin
      run_fetch(hs[z], bs[z], 0, 0, 0, 0);
      vectors++;
      if (n_sr - b_sr != 0) begin miscompares++; $display("FAIL zero%0d_start_read: got %0d required 0", z, n_sr - b_sr); end
      vectors++;
      if (done_cyc - sf_cyc != 1) begin miscompares++; $display("FAIL zero%0d_done_latency: got %0d required 1", z, done_cyc - sf_cyc); end
      vectors++;
      if (got_q.size() != 0 || n_done - b_done != 1) begin
        miscompares++;
        $display("FAIL zero%0d_lines: got lines=%0d done=%0d required 0 and 1", z, got_q.size(), n_done - b_done);
      end
    end
  endtask

  task automatic test_done_read;
    run_fetch(4, 2, 0, 0, 1, 0);
    build_exp(4, 2, 2);
    vectors++;
    if (got_q.size() != 2) begin miscompares++; $display("FAIL early_lines: got %0d required 2", got_q.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      vectors++;
      if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin
        miscompares++;
        $display("FAIL early_line%0d: got %h required %h", k, (k < got_q.size()) ? got_q[k] : '0, exp_q[k]);
      end
    end
    vectors++;
    if (n_rnl - b_rnl != 1 || n_done - b_done != 1) begin
      miscompares++;
      $display("FAIL early_pulses: got rnl=%0d done=%0d required 1 and 1", n_rnl - b_rnl, n_done - b_done);
    end
  endtask

  task automatic test_reset_mid;
    fill_words();
    snapshot();
    @(posedge clk); #1;
    num_of_history_frames = 3'd3;
    num_of_bbox_in_frame = 6'd4;
    start_fetch = 1'b1;
    @(posedge clk); #1;
    start_fetch = 1'b0;
    guard = 0;
    while (!(got_q.size() == 1 && line_valid) && guard < 200) begin
      line_ready = (got_q.size() == 0);
      @(posedge clk); #1;
      guard++;
    end
    line_ready = 1'b0;
    vectors++;
    if (guard >= 200) begin miscompares++; $display("FAIL midreset_reach_hold: got timeout required line 2 presented"); end
    #2 reset_N = 1'b0;
    #1;
    vectors++;
    if ({line_valid, start_read, read_new_line, rnw_st, fetch_busy, fetch_done, line_pair_valid,
         line_frame_idx, line_idx, line_data_0, line_data_1} !== '0) begin
      miscompares++;
      $display("FAIL midreset_async: got valid=%b rnw=%b busy=%b idx=%0d,%0d required all 0",
               line_valid, rnw_st, fetch_busy, line_frame_idx, line_idx);
    end
    @(posedge clk); #1;
    reset_N = 1'b1;
    run_fetch(3, 4, 1, 0, 0, 0);
    build_exp(3, 4, -1);
    vectors++;
    if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL midreset_lines: got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      vectors++;
      if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin
        miscompares++;
        $display("FAIL midreset_line%0d: got %h required %h", k, (k < got_q.size()) ? got_q[k] : '0, exp_q[k]);
      end
    end
  endtask

  task automatic test_random;
    int h, b;
    for (int r = 0; r < 6; r++) begin
      h = $urandom_range(1, 7);
      b = $urandom_range(1, 20);
      run_fetch(h, b, 1, 0, 0, 0);
      build_exp(h, b, -1);
      vectors++;
      if (got_q.size() != exp_q.size() || n_rnl - b_rnl != exp_q.size() - 1) begin
        miscompares++;
        $display("FAIL rand%0d_count h=%0d b=%0d: got lines=%0d rnl=%0d required %0d and %0d",
                 r, h, b, got_q.size(), n_rnl - b_rnl, exp_q.size(), exp_q.size() - 1);
      end
      for (int k = 0; k < exp_q.size(); k++) begin
        vectors++;
        if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin
          miscompares++;
          $display("FAIL rand%0d_line%0d: got %h required %h", r, k, (k < got_q.size()) ? got_q[k] : '0, exp_q[k]);
        end
      end
      vectors++;
      if (n_lat - b_lat != 0 || n_stab - b_stab != 0 || n_proto - b_proto != 0) begin
        miscompares++;
        $display("FAIL rand%0d_protocol: got lat=%0d stab=%0d proto=%0d required 0",
                 r, n_lat - b_lat, n_stab - b_stab, n_proto - b_proto);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_odd();
    test_stall();
    test_zero();
    test_done_read();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
